// File: rtl/noise_seq_pkg.sv
// noise_seq_pkg: shared types and constants for the noise channel step sequencer.
package noise_seq_pkg;

  localparam int STEP_W         = 41;
  localparam int ENV_TOGGLE_BIT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    APPLY = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       note_on;
    logic [7:0] r4;
    logic [7:0] r3;
    logic [7:0] r2;
    logic [7:0] r1;
    logic [7:0] r0;
  } step_t;

  // A tempo of zero would end every step instantly, so it behaves as one tick.
  function automatic logic [8:0] eff_tempo(input logic [7:0] tempo);
    return (tempo == 8'd0) ? 9'd1 : {1'b0, tempo};
  endfunction

endpackage

// File: rtl/noise_seq_tick.sv
// noise_seq_tick: free-running prescaler giving a one-cycle tempo tick every TICK_DIV clocks.
module noise_seq_tick
  import noise_seq_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_50mhz,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..TICK_DIV-1 and wrap; the tick marks the wrap cycle.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/noise_sequencer.sv
// noise_sequencer: plays a stored percussion pattern into the noise channel registers.
// Optional swing on odd steps is enabled by defining NOISE_SEQ_SWING_EN.
module noise_sequencer
  import noise_seq_pkg::*;
#(
  parameter int STEPS    = 16,
  parameter int ADDR_W   = $clog2(STEPS),
  parameter int TICK_DIV = 50000
) (
  input  logic              clk_50mhz,
  input  logic              reset_n,
  input  logic              run,
  input  logic [7:0]        tempo,
  input  logic [ADDR_W-1:0] last_step,
  input  logic [3:0]        swing,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STEP_W-1:0] wr_data,
  output logic [7:0]        reg_0,
  output logic [7:0]        reg_1,
  output logic [7:0]        reg_2,
  output logic [7:0]        reg_3,
  output logic [7:0]        reg_4,
  output logic [ADDR_W-1:0] step_idx,
  output logic              step_strobe,
  output logic              busy
);

  seq_state_t state, state_next;
  step_t      mem [STEPS];
  step_t      entry;
  logic       tick;
  logic [8:0] tick_cnt;
  logic [8:0] threshold;
  logic       step_done;
  logic       unused_bits;

  noise_seq_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_50mhz(clk_50mhz),
    .reset_n  (reset_n),
    .tick     (tick)
  );

  assign wr_ready  = (state != FETCH);
  assign busy      = (state != IDLE);
  assign step_done = (tick_cnt >= threshold);

`ifdef NOISE_SEQ_SWING_EN
  // Odd steps linger for the extra swing ticks; 9 bits hold 255 + 15 without overflow.
  always_comb begin
    threshold = eff_tempo(tempo);
    if (step_idx[0]) begin
      threshold = threshold + {5'd0, swing};
    end
  end
  assign unused_bits = entry.r0[ENV_TOGGLE_BIT];
`else
  // Every step lasts the same number of ticks; swing is accepted but has no effect.
  always_comb begin
    threshold = eff_tempo(tempo);
  end
  assign unused_bits = entry.r0[ENV_TOGGLE_BIT] ^ (^swing);
`endif

  // Pattern memory: host writes land at the edge, reads happen only in FETCH when writes are held off.
  always_ff @(posedge clk_50mhz) begin
    if (wr_valid && wr_ready) begin
      mem[wr_addr] <= step_t'(wr_data);
    end
    if (state == FETCH) begin
      entry <= mem[step_idx];
    end
  end

  // State register.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; dropping run returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (run) state_next = FETCH;
      FETCH:   state_next = APPLY;
      APPLY:   state_next = WAIT;
      WAIT:    if (step_done) state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (!run) begin
      state_next = IDLE;
    end
  end

  // Register outputs, step index and tick counting; the reg_0 bit-6 flip forces an envelope retrigger.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      reg_0       <= 8'd0;
      reg_1       <= 8'd0;
      reg_2       <= 8'd0;
      reg_3       <= 8'd0;
      reg_4       <= 8'd0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      tick_cnt    <= 9'd0;
    end else begin
      step_strobe <= 1'b0;
      if (state != IDLE && !run) begin
        reg_0    <= {1'b0, reg_0[ENV_TOGGLE_BIT], 6'd0};
        step_idx <= '0;
        tick_cnt <= 9'd0;
      end else begin
        unique case (state)
          IDLE: begin
            step_idx <= '0;
            tick_cnt <= 9'd0;
          end
          APPLY: begin
            if (entry.note_on) begin
              reg_0 <= {entry.r0[7], ~reg_0[ENV_TOGGLE_BIT], entry.r0[5:0]};
              reg_1 <= entry.r1;
              reg_2 <= entry.r2;
              reg_3 <= entry.r3;
              reg_4 <= entry.r4;
            end
            step_strobe <= 1'b1;
            tick_cnt    <= 9'd0;
          end
          WAIT: begin
            if (step_done) begin
              step_idx <= (step_idx >= last_step) ? '0 : step_idx + 1'b1;
            end else if (tick) begin
              tick_cnt <= tick_cnt + 9'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noise_sequencer.sv
// tb_noise_sequencer: directed self-checking bench for noise_sequencer (TICK_DIV = 10).
module tb_noise_sequencer;

  localparam int STEPS    = 16;
  localparam int ADDR_W   = 4;
  localparam int TICK_DIV = 10;
`ifdef NOISE_SEQ_SWING_EN
  localparam int ODD_CYC  = 50;
`else
  localparam int ODD_CYC  = 20;
`endif

  localparam logic [40:0] S0  = {1'b1, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h3F};
  localparam logic [40:0] S1  = {1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h85};
  localparam logic [40:0] S2  = {1'b1, 8'h05, 8'h06, 8'h07, 8'h08, 8'h92};
  localparam logic [40:0] S3  = {1'b1, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'hC1};
  localparam logic [40:0] S1N = {1'b1, 8'h00, 8'h00, 8'h00, 8'h55, 8'h05};

  logic              clk_50mhz = 1'b0;
  logic              reset_n   = 1'b0;
  logic              run       = 1'b0;
  logic [7:0]        tempo     = 8'd3;
  logic [ADDR_W-1:0] last_step = 4'd3;
  logic [3:0]        swing     = 4'd0;
  logic              wr_valid  = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr   = '0;
  logic [40:0]       wr_data   = '0;
  logic [7:0]        reg_0, reg_1, reg_2, reg_3, reg_4;
  logic [ADDR_W-1:0] step_idx;
  logic              step_strobe;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  noise_sequencer #(
    .STEPS   (STEPS),
    .ADDR_W  (ADDR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .reset_n    (reset_n),
    .run        (run),
    .tempo      (tempo),
    .last_step  (last_step),
    .swing      (swing),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .reg_0      (reg_0),
    .reg_1      (reg_1),
    .reg_2      (reg_2),
    .reg_3      (reg_3),
    .reg_4      (reg_4),
    .step_idx   (step_idx),
    .step_strobe(step_strobe),
    .busy       (busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] t, input logic [3:0] ls, input logic [3:0] sw);
    tempo     = t;
    last_step = ls;
    swing     = sw;
  endtask

  task automatic writeStep(input logic [3:0] addr, input logic [40:0] data);
    @(negedge clk_50mhz);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    @(negedge clk_50mhz);
    wr_valid = 1'b0;
  endtask

  task automatic waitStrobe(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk_50mhz);
      waited++;
    end while (!step_strobe && waited < budget);
    if (!step_strobe) checkOutput("strobe_timeout", {31'd0, step_strobe}, 32'd1);
  endtask

  initial begin
    int n;
    int lows;
    logic r1, r2;

    // Reset state
    repeat (3) @(negedge clk_50mhz);
    checkOutput("reset_reg_0", 32'(reg_0), 32'h0);
    checkOutput("reset_reg_4to1", {reg_4, reg_3, reg_2, reg_1}, 32'h0);
    checkOutput("reset_step_idx", 32'(step_idx), 32'd0);
    checkOutput("reset_strobe", 32'(step_strobe), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;

    writeStep(4'd0, S0);
    writeStep(4'd1, S1);
    writeStep(4'd2, S2);
    writeStep(4'd3, S3);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);

    // First note: two cycles of fetch/apply latency
    applyStimulus(8'd3, 4'd3, 4'd0);
    run = 1'b1;
    @(negedge clk_50mhz);
    checkOutput("fetch_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("fetch_busy", 32'(busy), 32'd1);
    @(negedge clk_50mhz);
    checkOutput("apply_reg_0_pending", 32'(reg_0), 32'h0);
    checkOutput("apply_strobe_pending", 32'(step_strobe), 32'd0);
    @(negedge clk_50mhz);
    checkOutput("s0_reg_0", 32'(reg_0), 32'h7F);
    checkOutput("s0_reg_3", 32'(reg_3), 32'h2A);
    checkOutput("s0_strobe", 32'(step_strobe), 32'd1);
    checkOutput("s0_idx", 32'(step_idx), 32'd0);
    @(negedge clk_50mhz);
    checkOutput("strobe_one_cycle", 32'(step_strobe), 32'd0);

    // Lap one: rest on step 1, bit 6 alternating on notes
    waitStrobe(400, n);
    checkOutput("s1_idx", 32'(step_idx), 32'd1);
    checkOutput("s1_rest_reg_0", 32'(reg_0), 32'h7F);
    checkOutput("s1_rest_regs", {reg_4, reg_3, reg_2, reg_1}, 32'h002A0000);
    waitStrobe(400, n);
    checkOutput("s2_period", n, 30);
    checkOutput("s2_idx", 32'(step_idx), 32'd2);
    checkOutput("s2_reg_0", 32'(reg_0), 32'h92);
    checkOutput("s2_regs", {reg_4, reg_3, reg_2, reg_1}, 32'h05060708);
    waitStrobe(400, n);
    checkOutput("s3_period", n, 30);
    checkOutput("s3_idx", 32'(step_idx), 32'd3);
    checkOutput("s3_reg_0", 32'(reg_0), 32'hC1);
    waitStrobe(400, n);
    checkOutput("wrap_period", n, 30);
    checkOutput("wrap_idx", 32'(step_idx), 32'd0);
    checkOutput("wrap_reg_0", 32'(reg_0), 32'h3F);
    waitStrobe(400, n);
    checkOutput("lap2_s1_reg_0", 32'(reg_0), 32'h3F);
    waitStrobe(400, n);
    checkOutput("lap2_s2_reg_0", 32'(reg_0), 32'hD2);

    // Stop in the middle of step 2
    repeat (5) @(negedge clk_50mhz);
    run = 1'b0;
    @(negedge clk_50mhz);
    checkOutput("stop_reg_0", 32'(reg_0), 32'h40);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_idx", 32'(step_idx), 32'd0);
    checkOutput("stop_reg_4", 32'(reg_4), 32'h05);

    // Restart replays step 0
    run = 1'b1;
    waitStrobe(10, n);
    checkOutput("restart_latency", n, 3);
    checkOutput("restart_idx", 32'(step_idx), 32'd0);
    checkOutput("restart_reg_0", 32'(reg_0), 32'h3F);

    // Host write held through the next fetch
    wr_valid = 1'b1;
    wr_addr  = 4'd1;
    wr_data  = S1N;
    lows = 0;
    r1 = 1'b1;
    r2 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50mhz);
      if (!wr_ready) lows++;
      if (step_strobe) break;
      r2 = r1;
      r1 = wr_ready;
    end
    checkOutput("held_strobe_seen", 32'(step_strobe), 32'd1);
    checkOutput("held_ready_lows", lows, 1);
    checkOutput("held_ready_fetch", 32'(r2), 32'd0);
    checkOutput("held_ready_apply", 32'(r1), 32'd1);
    wr_valid = 1'b0;
    checkOutput("new_s1_idx", 32'(step_idx), 32'd1);
    checkOutput("new_s1_reg_0", 32'(reg_0), 32'h45);
    checkOutput("new_s1_reg_1", 32'(reg_1), 32'h55);

    // Swing: tempo 2, swing 3
    applyStimulus(8'd2, 4'd3, 4'd3);
    waitStrobe(400, n);
    checkOutput("swing_odd1_period", n, ODD_CYC);
    checkOutput("swing_s2_idx", 32'(step_idx), 32'd2);
    waitStrobe(400, n);
    checkOutput("swing_even_period", n, 20);
    waitStrobe(400, n);
    checkOutput("swing_odd3_period", n, ODD_CYC);
    checkOutput("swing_s0_reg_0", 32'(reg_0), 32'h3F);

    // Tempo zero acts as one tick; lowering last_step below step_idx wraps
    applyStimulus(8'd0, 4'd3, 4'd0);
    waitStrobe(400, n);
    checkOutput("tempo0_period", n, 10);
    checkOutput("tempo0_reg_0", 32'(reg_0), 32'h45);
    waitStrobe(400, n);
    checkOutput("tempo0_s2_idx", 32'(step_idx), 32'd2);
    applyStimulus(8'd0, 4'd1, 4'd0);
    waitStrobe(400, n);
    checkOutput("lowered_last_idx", 32'(step_idx), 32'd0);
    checkOutput("lowered_last_reg_0", 32'(reg_0), 32'h7F);

    // Reset mid-step; pattern survives
    repeat (3) @(negedge clk_50mhz);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_reg_0", 32'(reg_0), 32'h0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_strobe", 32'(step_strobe), 32'd0);
    run = 1'b0;
    applyStimulus(8'd3, 4'd3, 4'd0);
    @(negedge clk_50mhz);
    reset_n = 1'b1;
    @(negedge clk_50mhz);
    run = 1'b1;
    waitStrobe(10, n);
    checkOutput("post_reset_latency", n, 3);
    checkOutput("post_reset_reg_0", 32'(reg_0), 32'h7F);
    checkOutput("post_reset_reg_3", 32'(reg_3), 32'h2A);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
